// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Channel mode encoding, default counter width and half-period math.
package clock_divider_pkg;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } div_mode_t;

    localparam int DEF_WIDTH = 24;

    // ceil(d/2) done with one spare bit so d = all-ones cannot overflow
    function automatic logic [31:0] half_period(input logic [31:0] d);
        logic [32:0] s;
        s = {1'b0, d} + 33'd1;
        return s[32:1];
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: active/pending divisor registers, period counter
// and registered square/pulse decode that always matches the counter.
module clock_divider_channel
    import clock_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] divisor,
    input  logic             mode,
    input  logic             load,
    input  logic             sync,
    output logic             outclk,
    output logic             tick,
    output logic             pending
);

    logic [WIDTH-1:0] cnt_q, d_q, pend_d_q;
    div_mode_t        mode_q, pend_mode_q;
    logic             pend_q, run_q;

    logic [WIDTH-1:0] cnt_n, d_n, src_d;
    div_mode_t        mode_n, src_mode;
    logic             idle, wrap, src_valid, apply, act_n, tick_n, outclk_n;
    logic [31:0]      h_n;

    always_comb begin
        // run_q means the counter held a live value last cycle (enabled, D != 0)
        idle      = !run_q || !enable;
        wrap      = run_q && (cnt_q == d_q - WIDTH'(1));
        src_valid = load || pend_q;
        src_d     = load ? divisor : pend_d_q;
        src_mode  = load ? div_mode_t'(mode) : pend_mode_q;
        apply     = src_valid && (idle || wrap || sync);
        d_n       = apply ? src_d : d_q;
        mode_n    = apply ? src_mode : mode_q;
        act_n     = enable && (d_n != '0);

        if (!act_n || idle || apply || sync || wrap)
            cnt_n = '0;
        else
            cnt_n = cnt_q + WIDTH'(1);

        h_n      = half_period(32'(d_n));
        tick_n   = act_n && (cnt_n == d_n - WIDTH'(1));
        outclk_n = act_n && ((mode_n == MODE_PULSE) ? tick_n : (32'(cnt_n) < h_n));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= '0;
            d_q         <= '0;
            mode_q      <= MODE_SQUARE;
            pend_d_q    <= '0;
            pend_mode_q <= MODE_SQUARE;
            pend_q      <= 1'b0;
            run_q       <= 1'b0;
            outclk      <= 1'b0;
            tick        <= 1'b0;
        end else begin
            cnt_q  <= cnt_n;
            d_q    <= d_n;
            mode_q <= mode_n;
            if (load) begin
                pend_d_q    <= divisor;
                pend_mode_q <= div_mode_t'(mode);
            end
            pend_q <= src_valid && !apply;
            run_q  <= act_n;
            outclk <= outclk_n;
            tick   <= tick_n;
        end
    end

    assign pending = pend_q;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock-enable generator; one independent
// divider per channel, sharing only clock, reset and the sync restart.
module clock_divider_multi
    import clock_divider_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS*WIDTH-1:0] divisor,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       load,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       outClk,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       pending
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        clock_divider_channel #(.WIDTH(WIDTH)) u_ch (
            .clock   (clock),
            .reset   (reset),
            .enable  (enable[i]),
            .divisor (divisor[i*WIDTH +: WIDTH]),
            .mode    (mode[i]),
            .load    (load[i]),
            .sync    (sync),
            .outclk  (outClk[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scenario bench for clock_divider_multi: expected output sequences are
// queued when stimulus is applied and popped cycle by cycle.
module tb_clock_divider_multi;

    localparam int CH = 4;
    localparam int W  = 24;

    logic            clock = 1'b0;
    logic            reset;
    logic [CH-1:0]   enable;
    logic [CH*W-1:0] divisor;
    logic [CH-1:0]   mode;
    logic [CH-1:0]   load;
    logic            sync;
    logic [CH-1:0]   outClk, tick, pending;

    int total  = 0;
    int passed = 0;
    logic [7:0] sbq[$];
    logic [7:0] exp_v, got;

    clock_divider_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .divisor (divisor),
        .mode    (mode),
        .load    (load),
        .sync    (sync),
        .outClk  (outClk),
        .tick    (tick),
        .pending (pending)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_div(input int ch, input int d, input bit m);
        logic [31:0] dv;
        dv = d;
        divisor[ch*W +: W] = dv[W-1:0];
        mode[ch] = m;
        load[ch] = 1'b1;
    endtask

    task automatic wait_tick(input int ch);
        int n;
        n = 0;
        while (tick[ch] !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        total++;
        if (tick[ch] !== 1'b1)
            $display("FAIL wait_tick ch%0d: tick=%b, required 1 within 20 cycles", ch, tick[ch]);
        else
            passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = '1; load = '1; sync = 1'b0; mode = '0;
        for (int i = 0; i < CH; i++) divisor[i*W +: W] = W'(4);
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if ({outClk, tick, pending} !== 12'h000)
                $display("FAIL reset[%0d]: out=%b tick=%b pend=%b, required all 0", i, outClk, tick, pending);
            else
                passed++;
        end
        reset = 1'b0; load = '0;
        cyc(); cyc();
        total++;
        if ({outClk, tick, pending} !== 12'h000)
            $display("FAIL reset_noload: out=%b tick=%b pend=%b, required all 0", outClk, tick, pending);
        else
            passed++;
    endtask

    task automatic test_square();
        set_div(0, 4, 1'b0);
        cyc();
        load = '0;
        for (int i = 0; i < 12; i++) sbq.push_back(8'({(i % 4) < 2, (i % 4) == 3}));
        for (int i = 0; i < 12; i++) begin
            got = 8'({outClk[0], tick[0]});
            exp_v = sbq.pop_front();
            total++;
            if (got !== exp_v) $display("FAIL square_d4[%0d]: got %b, required %b", i, got[1:0], exp_v[1:0]);
            else passed++;
            cyc();
        end
    endtask

    task automatic test_multi();
        set_div(1, 5, 1'b0);
        set_div(2, 3, 1'b1);
        cyc();
        load = '0;
        for (int i = 0; i < 15; i++)
            sbq.push_back(8'({(i % 5) < 3, (i % 3) == 2, (i % 5) == 4, (i % 3) == 2}));
        for (int i = 0; i < 15; i++) begin
            got = 8'({outClk[1], outClk[2], tick[1], tick[2]});
            exp_v = sbq.pop_front();
            total++;
            if (got !== exp_v) $display("FAIL multi_d5sq_d3pl[%0d]: got %b, required %b", i, got[3:0], exp_v[3:0]);
            else passed++;
            cyc();
        end
    endtask

    task automatic test_reload();
        wait_tick(0);
        cyc();
        set_div(0, 6, 1'b0);
        cyc();
        load = '0;
        sbq.push_back(8'b110); sbq.push_back(8'b100); sbq.push_back(8'b101);
        for (int i = 0; i < 12; i++) sbq.push_back(8'({1'b0, (i % 6) < 3, (i % 6) == 5}));
        for (int i = 0; i < 15; i++) begin
            got = 8'({pending[0], outClk[0], tick[0]});
            exp_v = sbq.pop_front();
            total++;
            if (got !== exp_v) $display("FAIL reload_4to6[%0d]: got %b, required %b", i, got[2:0], exp_v[2:0]);
            else passed++;
            cyc();
        end
    endtask

    task automatic test_idle_load();
        wait_tick(0);
        cyc();
        set_div(0, 0, 1'b0);
        cyc();
        load = '0;
        sbq.push_back(8'b110); sbq.push_back(8'b110); sbq.push_back(8'b100);
        sbq.push_back(8'b100); sbq.push_back(8'b101);
        for (int i = 0; i < 6; i++) sbq.push_back(8'b000);
        for (int i = 0; i < 11; i++) begin
            got = 8'({pending[0], outClk[0], tick[0]});
            exp_v = sbq.pop_front();
            total++;
            if (got !== exp_v) $display("FAIL load_d0[%0d]: got %b, required %b", i, got[2:0], exp_v[2:0]);
            else passed++;
            cyc();
        end
        set_div(0, 2, 1'b0);
        cyc();
        load = '0;
        for (int i = 0; i < 6; i++) sbq.push_back(8'({1'b0, (i % 2) == 0, (i % 2) == 1}));
        for (int i = 0; i < 6; i++) begin
            got = 8'({pending[0], outClk[0], tick[0]});
            exp_v = sbq.pop_front();
            total++;
            if (got !== exp_v) $display("FAIL idle_load_d2[%0d]: got %b, required %b", i, got[2:0], exp_v[2:0]);
            else passed++;
            cyc();
        end
    endtask

    task automatic test_d1();
        set_div(3, 1, 1'b0);
        cyc();
        load = '0;
        for (int i = 0; i < 4; i++) sbq.push_back(8'b11);
        for (int i = 0; i < 4; i++) begin
            got = 8'({outClk[3], tick[3]});
            exp_v = sbq.pop_front();
            total++;
            if (got !== exp_v) $display("FAIL d1_const[%0d]: got %b, required %b", i, got[1:0], exp_v[1:0]);
            else passed++;
            cyc();
        end
    endtask

    task automatic test_sync();
        int r;
        enable[1:0] = 2'b00;
        set_div(0, 4, 1'b0);
        set_div(1, 6, 1'b0);
        cyc();
        load = '0;
        total++;
        if ({pending[1:0], outClk[1:0]} !== 4'b0000)
            $display("FAIL disabled_load: pend=%b out=%b, required 00 00", pending[1:0], outClk[1:0]);
        else
            passed++;
        enable[0] = 1'b1;
        r = $urandom_range(1, 5);
        repeat (r) cyc();
        enable[1] = 1'b1;
        r = $urandom_range(1, 7);
        repeat (r) cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        for (int i = 0; i < 24; i++)
            sbq.push_back(8'({(i % 4) < 2, (i % 6) < 3, (i % 4) == 3, (i % 6) == 5}));
        for (int i = 0; i < 24; i++) begin
            got = 8'({outClk[0], outClk[1], tick[0], tick[1]});
            exp_v = sbq.pop_front();
            total++;
            if (got !== exp_v) $display("FAIL sync_d4_d6[%0d]: got %b, required %b", i, got[3:0], exp_v[3:0]);
            else passed++;
            cyc();
        end
    endtask

    task automatic test_enable();
        wait_tick(0);
        cyc();
        cyc();
        enable[0] = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i < 5) sbq.push_back(8'b00);
            else sbq.push_back(8'({((i - 5) % 4) < 2, ((i - 5) % 4) == 3}));
        end
        for (int i = 0; i < 13; i++) begin
            cyc();
            got = 8'({outClk[0], tick[0]});
            exp_v = sbq.pop_front();
            total++;
            if (got !== exp_v) $display("FAIL enable_gap[%0d]: got %b, required %b", i, got[1:0], exp_v[1:0]);
            else passed++;
            if (i == 4) enable[0] = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; enable = '0; divisor = '0; mode = '0; load = '0; sync = 1'b0;
        test_reset();
        test_square();
        test_multi();
        test_reload();
        test_idle_load();
        test_d1();
        test_sync();
        test_enable();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
